// File: rtl/rob_pkg.sv
// rtl/rob_pkg.sv - shared parameters, entry type and pointer helper for the reorder buffer
package rob_pkg;
    localparam int ROB_DEPTH = 32;
    localparam int ROB_ID_W  = $clog2(ROB_DEPTH);
    localparam int XLEN      = 32;
    localparam int REG_ID_W  = 5;

    typedef struct packed {
        logic                busy;
        logic                ready;
        logic                has_rd;
        logic [REG_ID_W-1:0] rd;
        logic [XLEN-1:0]     value;
        logic [XLEN-1:0]     pc;
        logic                is_branch;
        logic                pred_taken;
        logic                act_taken;
        logic [XLEN-1:0]     target;
    } rob_entry_t;

    function automatic logic [ROB_ID_W-1:0] rob_ptr_inc(input logic [ROB_ID_W-1:0] ptr);
        return ptr + {{(ROB_ID_W-1){1'b0}}, 1'b1};
    endfunction
endpackage

// File: rtl/reorder_buffer_if.sv
// rtl/reorder_buffer_if.sv - issue, rename, CDB, query, commit and flush signals of the reorder buffer
interface reorder_buffer_if;
    import rob_pkg::*;

    logic                issue_valid;
    logic                issue_has_rd;
    logic [REG_ID_W-1:0] issue_rd;
    logic [XLEN-1:0]     issue_pc;
    logic                issue_is_branch;
    logic                issue_pred_taken;
    logic                rob_full;
    logic [ROB_ID_W-1:0] rob_issue_id;
    logic [ROB_ID_W-1:0] rob_head_id;
    logic                rob_launch_ready;
    logic [ROB_ID_W-1:0] rob_launch_rob_id;
    logic [REG_ID_W-1:0] rob_launch_register_id;
    logic                cdb_valid;
    logic [ROB_ID_W-1:0] cdb_rob_id;
    logic [XLEN-1:0]     cdb_value;
    logic                cdb_branch_taken;
    logic [XLEN-1:0]     cdb_branch_target;
    logic [ROB_ID_W-1:0] query_id_1;
    logic [ROB_ID_W-1:0] query_id_2;
    logic                query_ready_1;
    logic                query_ready_2;
    logic [XLEN-1:0]     query_value_1;
    logic [XLEN-1:0]     query_value_2;
    logic                rob_commit_ready;
    logic [ROB_ID_W-1:0] rob_commit_rob_id;
    logic [REG_ID_W-1:0] rob_commit_register_id;
    logic [XLEN-1:0]     rob_commit_value;
    logic                flush_out;
    logic [XLEN-1:0]     flush_pc;

    modport master (
        output issue_valid, issue_has_rd, issue_rd, issue_pc, issue_is_branch, issue_pred_taken,
        output cdb_valid, cdb_rob_id, cdb_value, cdb_branch_taken, cdb_branch_target,
        output query_id_1, query_id_2,
        input  rob_full, rob_issue_id, rob_head_id,
        input  rob_launch_ready, rob_launch_rob_id, rob_launch_register_id,
        input  query_ready_1, query_ready_2, query_value_1, query_value_2,
        input  rob_commit_ready, rob_commit_rob_id, rob_commit_register_id, rob_commit_value,
        input  flush_out, flush_pc
    );

    modport slave (
        input  issue_valid, issue_has_rd, issue_rd, issue_pc, issue_is_branch, issue_pred_taken,
        input  cdb_valid, cdb_rob_id, cdb_value, cdb_branch_taken, cdb_branch_target,
        input  query_id_1, query_id_2,
        output rob_full, rob_issue_id, rob_head_id,
        output rob_launch_ready, rob_launch_rob_id, rob_launch_register_id,
        output query_ready_1, query_ready_2, query_value_1, query_value_2,
        output rob_commit_ready, rob_commit_rob_id, rob_commit_register_id, rob_commit_value,
        output flush_out, flush_pc
    );
endinterface

// File: rtl/reorder_buffer.sv
// rtl/reorder_buffer.sv - circular reorder buffer: allocate, rename, capture CDB, in-order commit, mispredict flush
module reorder_buffer
    import rob_pkg::*;
(
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             rdy_in,
    reorder_buffer_if.slave  bus
);
    rob_entry_t          rob [ROB_DEPTH];
    logic [ROB_ID_W-1:0] head;
    logic [ROB_ID_W-1:0] tail;
    logic [ROB_ID_W:0]   count;
    rob_entry_t          head_e;
    logic                commit_fire;
    logic                flush_pending;
    logic                accept;

    assign head_e        = rob[head];
    assign bus.rob_full  = (count == (ROB_ID_W+1)'(ROB_DEPTH));
    assign commit_fire   = rdy_in & head_e.busy & head_e.ready;
    assign flush_pending = commit_fire & head_e.is_branch & (head_e.act_taken != head_e.pred_taken);
    assign accept        = bus.issue_valid & ~bus.rob_full & rdy_in & ~flush_pending;

    assign bus.rob_issue_id           = tail;
    assign bus.rob_head_id            = head;
    assign bus.rob_launch_ready       = accept & bus.issue_has_rd & (bus.issue_rd != '0);
    assign bus.rob_launch_rob_id      = tail;
    assign bus.rob_launch_register_id = bus.issue_rd;

    // Operand lookup: a result broadcast this cycle is forwarded before it lands in the entry.
    always_comb begin
        bus.query_ready_1 = 1'b0;
        bus.query_value_1 = '0;
        if (rob[bus.query_id_1].busy) begin
            if (rdy_in && bus.cdb_valid && bus.cdb_rob_id == bus.query_id_1) begin
                bus.query_ready_1 = 1'b1;
                bus.query_value_1 = bus.cdb_value;
            end else if (rob[bus.query_id_1].ready) begin
                bus.query_ready_1 = 1'b1;
                bus.query_value_1 = rob[bus.query_id_1].value;
            end
        end
    end

    always_comb begin
        bus.query_ready_2 = 1'b0;
        bus.query_value_2 = '0;
        if (rob[bus.query_id_2].busy) begin
            if (rdy_in && bus.cdb_valid && bus.cdb_rob_id == bus.query_id_2) begin
                bus.query_ready_2 = 1'b1;
                bus.query_value_2 = bus.cdb_value;
            end else if (rob[bus.query_id_2].ready) begin
                bus.query_ready_2 = 1'b1;
                bus.query_value_2 = rob[bus.query_id_2].value;
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int i = 0; i < ROB_DEPTH; i++) rob[i] <= '0;
            bus.rob_commit_ready       <= 1'b0;
            bus.rob_commit_rob_id      <= '0;
            bus.rob_commit_register_id <= '0;
            bus.rob_commit_value       <= '0;
            bus.flush_out              <= 1'b0;
            bus.flush_pc               <= '0;
        end else begin
            bus.rob_commit_ready <= 1'b0;
            bus.flush_out        <= 1'b0;
            if (rdy_in) begin
                if (bus.cdb_valid && rob[bus.cdb_rob_id].busy) begin
                    rob[bus.cdb_rob_id].value     <= bus.cdb_value;
                    rob[bus.cdb_rob_id].act_taken <= bus.cdb_branch_taken;
                    rob[bus.cdb_rob_id].target    <= bus.cdb_branch_target;
                    rob[bus.cdb_rob_id].ready     <= 1'b1;
                end
                if (commit_fire) begin
                    rob[head].busy             <= 1'b0;
                    rob[head].ready            <= 1'b0;
                    bus.rob_commit_ready       <= head_e.has_rd && (head_e.rd != '0);
                    bus.rob_commit_rob_id      <= head;
                    bus.rob_commit_register_id <= head_e.rd;
                    bus.rob_commit_value       <= head_e.value;
                    head                       <= rob_ptr_inc(head);
                end
                if (accept) begin
                    rob[tail] <= '{busy: 1'b1, ready: 1'b0, has_rd: bus.issue_has_rd,
                                   rd: bus.issue_rd, value: '0, pc: bus.issue_pc,
                                   is_branch: bus.issue_is_branch,
                                   pred_taken: bus.issue_pred_taken,
                                   act_taken: 1'b0, target: '0};
                    tail <= rob_ptr_inc(tail);
                end
                if (accept && !commit_fire)
                    count <= count + (ROB_ID_W+1)'(1);
                else if (!accept && commit_fire)
                    count <= count - (ROB_ID_W+1)'(1);
                // Mispredict overrides every other update made at this edge.
                if (flush_pending) begin
                    bus.flush_out <= 1'b1;
                    bus.flush_pc  <= head_e.act_taken ? head_e.target : head_e.pc + XLEN'(4);
                    head  <= '0;
                    tail  <= '0;
                    count <= '0;
                    for (int i = 0; i < ROB_DEPTH; i++) begin
                        rob[i].busy  <= 1'b0;
                        rob[i].ready <= 1'b0;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_reorder_buffer.sv
// tb/tb_reorder_buffer.sv - scoreboard bench for reorder_buffer
module tb_reorder_buffer;
    import rob_pkg::*;

    typedef struct {
        logic [4:0]  id;
        logic [4:0]  rd;
        logic [31:0] val;
    } exp_commit_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    logic rdy   = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    exp_commit_t cq [$];
    logic [31:0] fq [$];
    logic [31:0] val_tab [32];

    reorder_buffer_if rif ();

    reorder_buffer dut (
        .clk_in (clk),
        .rst_in (rst_n),
        .rdy_in (rdy),
        .bus    (rif.slave)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_commit_t e;
        if (rif.rob_commit_ready === 1'b1) begin
            if (cq.size() == 0) begin
                check_eq("commit_unexpected", 64'(rif.rob_commit_rob_id), 64'hFF);
            end else begin
                e = cq.pop_front();
                check_eq("commit_id", 64'(rif.rob_commit_rob_id), 64'(e.id));
                check_eq("commit_rd", 64'(rif.rob_commit_register_id), 64'(e.rd));
                check_eq("commit_value", 64'(rif.rob_commit_value), 64'(e.val));
            end
        end
        if (rif.flush_out === 1'b1) begin
            if (fq.size() == 0)
                check_eq("flush_unexpected", 64'(rif.flush_pc), 64'hFFFF_FFFF_FFFF);
            else
                check_eq("flush_pc", 64'(rif.flush_pc), 64'(fq.pop_front()));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_issue(input logic [4:0] rd, input logic has_rd, input logic [31:0] pc,
                            input logic br, input logic pred, input logic exp_launch,
                            input logic [4:0] exp_id);
        rif.issue_valid      = 1'b1;
        rif.issue_has_rd     = has_rd;
        rif.issue_rd         = rd;
        rif.issue_pc         = pc;
        rif.issue_is_branch  = br;
        rif.issue_pred_taken = pred;
        @(negedge clk);
        check_eq("launch_ready", 64'(rif.rob_launch_ready), 64'(exp_launch));
        check_eq("issue_id", 64'(rif.rob_issue_id), 64'(exp_id));
        if (exp_launch) begin
            check_eq("launch_rob_id", 64'(rif.rob_launch_rob_id), 64'(exp_id));
            check_eq("launch_reg", 64'(rif.rob_launch_register_id), 64'(rd));
        end
        tick();
        rif.issue_valid = 1'b0;
    endtask

    task automatic do_cdb(input logic [4:0] id, input logic [31:0] val, input logic taken,
                          input logic [31:0] tgt);
        rif.cdb_valid         = 1'b1;
        rif.cdb_rob_id        = id;
        rif.cdb_value         = val;
        rif.cdb_branch_taken  = taken;
        rif.cdb_branch_target = tgt;
        tick();
        rif.cdb_valid = 1'b0;
    endtask

    initial begin
        logic [4:0]  id_v;
        logic [4:0]  rd_v;
        rif.issue_valid = 0; rif.issue_has_rd = 0; rif.issue_rd = 0; rif.issue_pc = 0;
        rif.issue_is_branch = 0; rif.issue_pred_taken = 0;
        rif.cdb_valid = 0; rif.cdb_rob_id = 0; rif.cdb_value = 0;
        rif.cdb_branch_taken = 0; rif.cdb_branch_target = 0;
        rif.query_id_1 = 0; rif.query_id_2 = 0;
        #1 rst_n = 1'b0;
        #11;
        check_eq("rst_full", 64'(rif.rob_full), 0);
        check_eq("rst_issue_id", 64'(rif.rob_issue_id), 0);
        check_eq("rst_head_id", 64'(rif.rob_head_id), 0);
        check_eq("rst_commit_ready", 64'(rif.rob_commit_ready), 0);
        check_eq("rst_flush", 64'(rif.flush_out), 0);
        check_eq("rst_query", 64'(rif.query_ready_1), 0);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();

        // single instruction: launch in issue cycle, commit two cycles after CDB
        cq.push_back('{5'd0, 5'd5, 32'h1234});
        do_issue(5'd5, 1'b1, 32'h0, 1'b0, 1'b0, 1'b1, 5'd0);
        do_cdb(5'd0, 32'h1234, 1'b0, 32'h0);
        @(negedge clk);
        check_eq("commit_lat_early", 64'(rif.rob_commit_ready), 0);
        @(negedge clk);
        check_eq("commit_lat_ontime", 64'(rif.rob_commit_ready), 1);
        tick();

        // fill all 32 entries starting at id 1; tail wraps back to 1
        for (int i = 0; i < 32; i++) begin
            id_v = 5'(1 + i);
            rd_v = 5'((i % 31) + 1);
            val_tab[id_v] = 32'hA000_0000 + 32'(i);
            cq.push_back('{id_v, rd_v, val_tab[id_v]});
            do_issue(rd_v, 1'b1, 32'h1000 + 32'(4 * i), 1'b0, 1'b0, 1'b1, id_v);
        end
        @(negedge clk);
        check_eq("full_after_32", 64'(rif.rob_full), 1);
        tick();
        do_issue(5'd3, 1'b1, 32'h2000, 1'b0, 1'b0, 1'b0, 5'd1);
        @(negedge clk);
        check_eq("full_33rd_ignored", 64'(rif.rob_issue_id), 1);
        tick();
        do_cdb(5'd1, val_tab[1], 1'b0, 32'h0);
        @(negedge clk);
        check_eq("full_before_commit", 64'(rif.rob_full), 1);
        @(negedge clk);
        check_eq("full_cleared", 64'(rif.rob_full), 0);
        tick();

        // out-of-order results: id 0 first, then 31 down to 2; commits must stream in order
        do_cdb(5'd0, val_tab[0], 1'b0, 32'h0);
        for (int j = 31; j >= 2; j--) do_cdb(5'(j), val_tab[j], 1'b0, 32'h0);
        @(negedge clk);
        for (int k = 0; k < 31; k++) begin
            @(negedge clk);
            check_eq("commit_stream", 64'(rif.rob_commit_ready), 1);
        end
        tick();

        // mispredicted branch at id 1, younger ready entry at id 2 must never commit
        do_issue(5'd0, 1'b0, 32'h100, 1'b1, 1'b0, 1'b0, 5'd1);
        do_issue(5'd7, 1'b1, 32'h104, 1'b0, 1'b0, 1'b1, 5'd2);
        do_issue(5'd8, 1'b1, 32'h108, 1'b0, 1'b0, 1'b1, 5'd3);
        do_cdb(5'd2, 32'h77, 1'b0, 32'h0);
        fq.push_back(32'h200);
        do_cdb(5'd1, 32'h0, 1'b1, 32'h200);
        rif.issue_valid = 1'b1; rif.issue_has_rd = 1'b1; rif.issue_rd = 5'd9;
        rif.issue_is_branch = 1'b0;
        @(negedge clk);
        check_eq("flush_launch_blocked", 64'(rif.rob_launch_ready), 0);
        tick();
        rif.issue_valid = 1'b0;
        @(negedge clk);
        check_eq("flush_pulse", 64'(rif.flush_out), 1);
        check_eq("flush_issue_id", 64'(rif.rob_issue_id), 0);
        check_eq("flush_head_id", 64'(rif.rob_head_id), 0);
        tick();

        // correctly predicted branch retires silently
        do_issue(5'd0, 1'b0, 32'h300, 1'b1, 1'b1, 1'b0, 5'd0);
        do_cdb(5'd0, 32'h0, 1'b1, 32'h400);
        repeat (2) tick();
        @(negedge clk);
        check_eq("good_branch_head", 64'(rif.rob_head_id), 1);
        tick();

        // rd=0 entry, then query bypass on id 3
        do_issue(5'd0, 1'b1, 32'h500, 1'b0, 1'b0, 1'b0, 5'd1);
        cq.push_back('{5'd2, 5'd10, 32'h2222});
        do_issue(5'd10, 1'b1, 32'h504, 1'b0, 1'b0, 1'b1, 5'd2);
        cq.push_back('{5'd3, 5'd11, 32'hABCD});
        do_issue(5'd11, 1'b1, 32'h508, 1'b0, 1'b0, 1'b1, 5'd3);
        rif.cdb_valid = 1'b1; rif.cdb_rob_id = 5'd3; rif.cdb_value = 32'hABCD;
        rif.cdb_branch_taken = 1'b0; rif.cdb_branch_target = 32'h0;
        rif.query_id_1 = 5'd3; rif.query_id_2 = 5'd2;
        @(negedge clk);
        check_eq("query_bypass_ready", 64'(rif.query_ready_1), 1);
        check_eq("query_bypass_value", 64'(rif.query_value_1), 64'h ABCD);
        check_eq("query_pending", 64'(rif.query_ready_2), 0);
        tick();
        rif.cdb_valid = 1'b0;
        rif.query_id_2 = 5'd20;
        @(negedge clk);
        check_eq("query_stored_ready", 64'(rif.query_ready_1), 1);
        check_eq("query_stored_value", 64'(rif.query_value_1), 64'hABCD);
        check_eq("query_idle_ready", 64'(rif.query_ready_2), 0);
        check_eq("query_idle_value", 64'(rif.query_value_2), 0);
        tick();

        // stall with head ready: nothing retires while rdy_in is low
        do_cdb(5'd2, 32'h2222, 1'b0, 32'h0);
        do_cdb(5'd1, 32'h1111, 1'b0, 32'h0);
        rdy = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check_eq("stall_commit", 64'(rif.rob_commit_ready), 0);
            check_eq("stall_head", 64'(rif.rob_head_id), 1);
            tick();
        end
        rdy = 1'b1;
        repeat (5) tick();
        @(negedge clk);
        check_eq("drain_after_stall", 64'(cq.size()), 0);
        tick();

        // asynchronous reset while a commit pulse is on the outputs
        cq.push_back('{5'd4, 5'd12, 32'h4444});
        do_issue(5'd12, 1'b1, 32'h600, 1'b0, 1'b0, 1'b1, 5'd4);
        cq.push_back('{5'd5, 5'd13, 32'h5555});
        do_issue(5'd13, 1'b1, 32'h604, 1'b0, 1'b0, 1'b1, 5'd5);
        do_cdb(5'd4, 32'h4444, 1'b0, 32'h0);
        do_cdb(5'd5, 32'h5555, 1'b0, 32'h0);
        #1;
        check_eq("pre_reset_commit", 64'(rif.rob_commit_ready), 1);
        rst_n = 1'b0;
        #1;
        check_eq("arst_commit_ready", 64'(rif.rob_commit_ready), 0);
        check_eq("arst_commit_value", 64'(rif.rob_commit_value), 0);
        check_eq("arst_commit_id", 64'(rif.rob_commit_rob_id), 0);
        check_eq("arst_flush_pc", 64'(rif.flush_pc), 0);
        check_eq("arst_issue_id", 64'(rif.rob_issue_id), 0);
        check_eq("arst_head_id", 64'(rif.rob_head_id), 0);
        cq.delete();
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (4) tick();
        @(negedge clk);
        check_eq("end_commit_queue", 64'(cq.size()), 0);
        check_eq("end_flush_queue", 64'(fq.size()), 0);
        check_eq("end_issue_id", 64'(rif.rob_issue_id), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/reorder_buffer.md
Name: reorder_buffer

Overview:
Circular 32-entry reorder buffer for the Tomasulo core. Allocates a ROB id per issued instruction and drives the register-file launch interface (rename). Captures CDB results and retires entries strictly in program order, driving the register-file commit interface. Detects branch mispredicts at commit and emits a pipeline flush.

Parameters:
ROB_DEPTH, 32, number of entries (power of two)
ROB_ID_W, 5, log2(ROB_DEPTH); width of every rob id
XLEN, 32, data/PC width

Ports:
clk_in  in  1  system clock
rst_in  in  1  asynchronous active-low reset
rdy_in  in  1  ready; state frozen when low
_issue_valid  in  1  decoder presents an instruction
_issue_has_rd  in  1  instruction writes a register
_issue_rd  in  5  destination register
_issue_pc  in  XLEN  instruction PC
_issue_is_branch  in  1  conditional branch
_issue_pred_taken  in  1  fetch prediction
_rob_full  out  1  no free entry
_rob_issue_id  out  ROB_ID_W  id allocated on accept (tail)
_rob_head_id  out  ROB_ID_W  oldest in-flight id
_rob_launch_ready  out  1  rename pulse to register file
_rob_launch_rob_id  out  ROB_ID_W  id bound to rd
_rob_launch_register_id  out  5  renamed register
_cdb_valid  in  1  result broadcast
_cdb_rob_id  in  ROB_ID_W  producing entry
_cdb_value  in  XLEN  result value
_cdb_branch_taken  in  1  resolved direction
_cdb_branch_target  in  XLEN  resolved taken target
_query_id_1 / _query_id_2  in  ROB_ID_W  operand dependency lookup
_query_ready_1 / _query_ready_2  out  1  value available
_query_value_1 / _query_value_2  out  XLEN  value
_rob_commit_ready  out  1  commit pulse to register file
_rob_commit_rob_id  out  ROB_ID_W  retiring id
_rob_commit_register_id  out  5  destination
_rob_commit_value  out  XLEN  value
_flush_out  out  1  mispredict flush pulse
_flush_pc  out  XLEN  redirect PC

Behaviour:
- Reset (rst_in=0, async): head=tail=0, count=0, all busy/ready cleared; every registered output 0.
- State: head, tail (ROB_ID_W, wrap modulo ROB_DEPTH), count (ROB_ID_W+1). _rob_full = (count==ROB_DEPTH), from registered count only; issue blocked when full even if a commit occurs in the same cycle.
- Accept = _issue_valid & ~_rob_full & rdy_in & ~flush_pending. On accept: entry[tail] busy=1, ready=0, fields stored; tail++.
- Launch: combinational, same cycle as accept; _rob_launch_ready = accept & has_rd & (rd!=0); rob_id = tail.
- CDB: at edge with _cdb_valid & rdy_in, if entry busy: store value/taken/target, ready=1. Write to non-busy entry ignored.
- Query: combinational; ready = entry busy & ready, or same-cycle CDB hit on that id (bypass, value from CDB). Non-busy id returns ready=0, value 0.
- Commit: at most one per cycle; condition head entry busy & ready (registered ready; a CDB write to head commits no earlier than next edge). Latency: commit outputs registered, valid the cycle after the deciding edge, one-cycle pulse. _rob_commit_ready only if has_rd & rd!=0; id/register/value updated on every retirement. head++, busy cleared.
- Simultaneous accept and commit: count unchanged.
- Mispredict: branch retiring with taken != pred_taken -> registered _flush_out=1 for one cycle, _flush_pc = target if taken else pc+4. Same edge: all busy cleared, head=tail=count=0; any same-cycle issue is discarded (no allocation; launch pulse suppressed via flush_pending). Correct branch retires silently.
- rdy_in=0: no pointer/entry updates, launch suppressed; commit/flush outputs forced to 0 at that edge.
- Reset mid-operation discards all entries; no commit or flush pulse is generated.

Decomposition:
- Package rob_pkg: ROB_DEPTH, ROB_ID_W, XLEN, REG_ID_W=5, rob_entry_t struct (busy, ready, has_rd, rd, value, pc, is_branch, pred_taken, act_taken, target), helper for pointer increment.
- Single flat module; no sub-module warranted.

Test Plan:
- Issue rd=5 at id 0, CDB id0 value 0x1234 -> launch (0,5) in issue cycle; commit pulse (0,5,0x1234) two cycles after CDB.
- Issue 32 instructions with no CDB -> _rob_full=1, 33rd issue ignored, tail wraps to 0; one commit -> full clears next cycle.
- Out-of-order CDB (id2 then id1 then id0) -> commits in order 0,1,2 on consecutive cycles.
- Branch pc=0x100 pred_taken=0, CDB taken=1 target=0x200 -> _flush_out pulse, _flush_pc=0x200, count=0, younger entries never commit.
- Query id3 in same cycle as CDB id3 value 0xABCD -> _query_ready=1, value 0xABCD; issue rd=0 -> no launch, commit_ready stays 0.
- rdy_in low 3 cycles with head ready -> no commit; async rst_in low mid-stream -> all outputs 0 immediately.
